// File: rtl/samp_buff_pkg.sv
// ==========================================================================
// samp_buff_pkg : shared types and width helpers for the capture buffer
// Revision 1.0
// ==========================================================================
`default_nettype none

package samp_buff_pkg;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ARMED   = 2'd1,
      ST_CAPTURE = 2'd2,
      ST_DONE    = 2'd3
   } state_t;

   localparam int RAM_RD_LATENCY = 1;

   function automatic int clog2(input int value);
      int res;
      int v;
      res = 0;
      v   = value - 1;
      while (v > 0) begin
         res++;
         v = v >> 1;
      end
      return res;
   endfunction

   function automatic int calc_width_wr(input int num_chan, input int samp_width);
      return num_chan * samp_width;
   endfunction

   function automatic int calc_depth_mult(input int width_wr, input int rd_width);
      return width_wr / rd_width;
   endfunction

   // A single-slice beat still needs a 1-bit slice index.
   function automatic int calc_slice_w(input int depth_mult);
      return (depth_mult > 1) ? clog2(depth_mult) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/samp_buff_ram.sv
// ==========================================================================
// samp_buff_ram : simple dual-port block RAM, registered read data
// Revision 1.0
// ==========================================================================
`default_nettype none

module samp_buff_ram #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 16,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   always_ff @(posedge clk) begin
      rd_data <= mem[rd_addr];
   end

endmodule

`default_nettype wire

// File: rtl/samp_buff_mc.sv
// ==========================================================================
// samp_buff_mc : armed/triggered multi-channel batch capture, sliced MPU readout
// Revision 1.0
// ==========================================================================
`default_nettype none

module samp_buff_mc
   import samp_buff_pkg::*;
#(
   parameter int NUM_CHAN   = 4,
   parameter int SAMP_WIDTH = 32,
   parameter int BUFF_DEPTH = 4096,
   parameter int RD_WIDTH   = 16,
   localparam int WIDTH_WR  = calc_width_wr(NUM_CHAN, SAMP_WIDTH),
   localparam int AW        = clog2(BUFF_DEPTH)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                arm,
   input  logic                trig_ext_en,
   input  logic                trig,
   input  logic [AW:0]         capture_len,
   input  logic                valid,
   input  logic [WIDTH_WR-1:0] samp_in,
   input  logic                rd_ena,
   output logic                busy,
   output logic                ready,
   output logic [AW:0]         samp_count,
   output logic [RD_WIDTH-1:0] data_out
);

   localparam int DEPTH_MULT = calc_depth_mult(WIDTH_WR, RD_WIDTH);
   localparam int SLW        = calc_slice_w(DEPTH_MULT);

   localparam logic [AW:0]    DEPTH_VAL  = (AW+1)'(BUFF_DEPTH);
   localparam logic [AW:0]    ONE_BEAT   = (AW+1)'(1);
   localparam logic [SLW-1:0] SLICE_LAST = SLW'(DEPTH_MULT - 1);
   localparam logic [SLW-1:0] SLICE_ONE  = SLW'(1);
   localparam logic [AW-1:0]  ADDR_ONE   = AW'(1);

   generate
      if ((WIDTH_WR < RD_WIDTH) || ((WIDTH_WR % RD_WIDTH) != 0)) begin : g_bad_rd_width
         $error("samp_buff_mc: NUM_CHAN*SAMP_WIDTH must be a positive multiple of RD_WIDTH");
      end
      if ((1 << AW) != BUFF_DEPTH) begin : g_bad_depth
         $error("samp_buff_mc: BUFF_DEPTH must be a power of 2");
      end
   endgenerate

   state_t                state;
   logic [AW:0]           len;
   logic [AW:0]           rd_beat;
   logic [SLW-1:0]        slice;
   logic [AW-1:0]         rd_addr;
   logic [1:0]            prime;
   logic                  rd_ena_d;
   logic [WIDTH_WR-1:0]   cur_beat;
   logic [WIDTH_WR-1:0]   ram_q;

   logic                  wr_fire;
   logic                  wr_last;
   logic                  rd_edge;
   logic [AW:0]           len_clamped;
   logic [AW:0]           len_last;
   logic [SLW-1:0]        slice_nxt;
   logic [RD_WIDTH-1:0]   beat_slices [DEPTH_MULT];

   // Slice 0 sits in the LSBs so channel 0 is read out first.
   generate
      for (genvar s = 0; s < DEPTH_MULT; s++) begin : g_slice
         assign beat_slices[s] = cur_beat[s*RD_WIDTH +: RD_WIDTH];
      end
   endgenerate

   assign len_clamped = ((capture_len == '0) || (capture_len > DEPTH_VAL)) ? DEPTH_VAL : capture_len;
   assign len_last    = len - ONE_BEAT;
   assign slice_nxt   = slice + SLICE_ONE;
   assign rd_edge     = rd_ena & ~rd_ena_d;

   assign wr_fire = ~arm & valid &
                    ((state == ST_CAPTURE) || ((state == ST_ARMED) && trig));
   assign wr_last = wr_fire && ((samp_count + ONE_BEAT) == len);

   samp_buff_ram #(
      .WIDTH (WIDTH_WR),
      .DEPTH (BUFF_DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_fire),
      .wr_addr (samp_count[AW-1:0]),
      .wr_data (samp_in),
      .rd_addr (rd_addr),
      .rd_data (ram_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_IDLE;
         len        <= '0;
         samp_count <= '0;
         rd_beat    <= '0;
         slice      <= '0;
         rd_addr    <= '0;
         prime      <= '0;
         rd_ena_d   <= 1'b0;
         cur_beat   <= '0;
         busy       <= 1'b0;
         ready      <= 1'b0;
         data_out   <= '0;
      end else begin
         rd_ena_d <= rd_ena;
         if (arm) begin
            state      <= trig_ext_en ? ST_ARMED : ST_CAPTURE;
            len        <= len_clamped;
            samp_count <= '0;
            rd_beat    <= '0;
            slice      <= '0;
            rd_addr    <= '0;
            prime      <= '0;
            busy       <= 1'b1;
            ready      <= 1'b0;
         end else begin
            case (state)
               ST_ARMED: begin
                  if (trig) begin
                     state <= ST_CAPTURE;
                  end
               end
               ST_DONE: begin
                  // Fetch beat 0, then park the RAM port on the next beat so a
                  // beat-boundary edge can be served from ram_q immediately.
                  prime <= {prime[0], 1'b0};
                  if (prime[0]) begin
                     rd_addr <= rd_addr + ADDR_ONE;
                  end
                  if (prime[1]) begin
                     cur_beat <= ram_q;
                     data_out <= ram_q[RD_WIDTH-1:0];
                     ready    <= 1'b1;
                  end else if (ready && rd_edge) begin
                     if (slice != SLICE_LAST) begin
                        slice    <= slice_nxt;
                        data_out <= beat_slices[slice_nxt];
                     end else if (rd_beat == len_last) begin
                        ready <= 1'b0;
                        state <= ST_IDLE;
                     end else begin
                        rd_beat  <= rd_beat + ONE_BEAT;
                        slice    <= '0;
                        cur_beat <= ram_q;
                        data_out <= ram_q[RD_WIDTH-1:0];
                        rd_addr  <= rd_addr + ADDR_ONE;
                     end
                  end
               end
               default: begin
               end
            endcase

            if (wr_fire) begin
               samp_count <= samp_count + ONE_BEAT;
               if (wr_last) begin
                  state   <= ST_DONE;
                  busy    <= 1'b0;
                  prime   <= 2'b01;
                  rd_addr <= '0;
                  rd_beat <= '0;
                  slice   <= '0;
               end
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_samp_buff_mc.sv
// ==========================================================================
// tb_samp_buff_mc : directed self-checking bench for samp_buff_mc
// Revision 1.0
// ==========================================================================
`default_nettype none

module tb_samp_buff_mc;

   localparam int NUM_CHAN   = 2;
   localparam int SAMP_WIDTH = 16;
   localparam int BUFF_DEPTH = 8;
   localparam int RD_WIDTH   = 16;
   localparam int AW         = 3;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          arm = 1'b0;
   logic          trig_ext_en = 1'b0;
   logic          trig = 1'b0;
   logic [AW:0]   capture_len = '0;
   logic          valid = 1'b0;
   logic [31:0]   samp_in = '0;
   logic          rd_ena = 1'b0;
   logic          busy;
   logic          ready;
   logic [AW:0]   samp_count;
   logic [15:0]   data_out;

   int n_vec = 0;
   int n_err = 0;

   samp_buff_mc #(
      .NUM_CHAN   (NUM_CHAN),
      .SAMP_WIDTH (SAMP_WIDTH),
      .BUFF_DEPTH (BUFF_DEPTH),
      .RD_WIDTH   (RD_WIDTH)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .arm         (arm),
      .trig_ext_en (trig_ext_en),
      .trig        (trig),
      .capture_len (capture_len),
      .valid       (valid),
      .samp_in     (samp_in),
      .rd_ena      (rd_ena),
      .busy        (busy),
      .ready       (ready),
      .samp_count  (samp_count),
      .data_out    (data_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_arm(input logic ext, input logic [AW:0] len);
      arm = 1'b1; trig_ext_en = ext; capture_len = len;
      tick();
      arm = 1'b0; trig_ext_en = 1'b0;
   endtask

   task automatic push(input logic [31:0] beat);
      valid = 1'b1; samp_in = beat;
      tick();
      valid = 1'b0;
   endtask

   task automatic wait_ready();
      int cnt;
      cnt = 0;
      while (!ready && cnt < 10) begin
         tick();
         cnt++;
      end
      check("ready_timeout", {31'd0, ready}, 32'd1);
   endtask

   // Single-cycle rd_ena pulse; the new slice must be visible the cycle after the edge.
   task automatic rd_step(input string tag, input logic [15:0] exp);
      rd_ena = 1'b1;
      tick();
      check(tag, {16'd0, data_out}, {16'd0, exp});
      rd_ena = 1'b0;
      tick();
   endtask

   initial begin
      // Reset state
      tick(); tick();
      check("rst_busy",  {31'd0, busy},  32'd0);
      check("rst_ready", {31'd0, ready}, 32'd0);
      check("rst_count", {28'd0, samp_count}, 32'd0);
      check("rst_data",  {16'd0, data_out}, 32'd0);
      rst = 1'b0;
      tick();

      // Immediate capture, len 3
      do_arm(1'b0, 4'd3);
      check("imm_busy_on", {31'd0, busy}, 32'd1);
      push(32'h0002_0001);
      push(32'h0004_0003);
      push(32'h0006_0005);
      check("imm_busy_off", {31'd0, busy}, 32'd0);
      check("imm_count", {28'd0, samp_count}, 32'd3);
      wait_ready();
      check("imm_s0", {16'd0, data_out}, 32'h0001);
      for (int i = 2; i <= 6; i++) rd_step("imm_slice", 16'(i));
      check("imm_ready_pre_end", {31'd0, ready}, 32'd1);
      rd_step("imm_last_hold", 16'h0006);
      check("imm_ready_end", {31'd0, ready}, 32'd0);
      check("imm_busy_end", {31'd0, busy}, 32'd0);
      rd_step("imm_idle_edge", 16'h0006);

      // Triggered capture, len 2; valid without trig is ignored
      do_arm(1'b1, 4'd2);
      for (int i = 0; i < 5; i++) begin
         valid = 1'b1; samp_in = 32'hDEAD_0000 + 32'(i);
         tick();
      end
      check("trg_wait_count", {28'd0, samp_count}, 32'd0);
      check("trg_wait_busy", {31'd0, busy}, 32'd1);
      trig = 1'b1; samp_in = 32'h00BB_00AA;
      tick();
      trig = 1'b0; samp_in = 32'h00DD_00CC;
      tick();
      valid = 1'b0;
      check("trg_count", {28'd0, samp_count}, 32'd2);
      wait_ready();
      check("trg_s0", {16'd0, data_out}, 32'h00AA);
      rd_ena = 1'b1;
      for (int i = 0; i < 20; i++) tick();
      check("hold_one_adv", {16'd0, data_out}, 32'h00BB);
      rd_ena = 1'b0;
      tick();
      rd_step("trg_cross", 16'h00CC);
      rd_step("trg_s3", 16'h00DD);
      rd_step("trg_end", 16'h00DD);
      check("trg_ready_end", {31'd0, ready}, 32'd0);

      // Length clamp: len 0 means 8 beats, extra beats dropped
      do_arm(1'b0, 4'd0);
      for (int k = 0; k < 10; k++) push({16'(16'h0011 + 2*k), 16'(16'h0010 + 2*k)});
      check("clamp_count", {28'd0, samp_count}, 32'd8);
      check("clamp_busy", {31'd0, busy}, 32'd0);
      wait_ready();
      check("clamp_s0", {16'd0, data_out}, 32'h0010);
      for (int i = 1; i < 16; i++) rd_step("clamp_slice", 16'(16'h0010 + i));
      rd_step("clamp_16th", 16'h001F);
      check("clamp_ready_end", {31'd0, ready}, 32'd0);
      rd_step("clamp_17th", 16'h001F);

      // Abort during readout
      do_arm(1'b0, 4'd2);
      push(32'h00A2_00A1);
      push(32'h00A4_00A3);
      wait_ready();
      rd_step("abort_pre", 16'h00A2);
      do_arm(1'b0, 4'd1);
      check("abort_ready", {31'd0, ready}, 32'd0);
      check("abort_busy", {31'd0, busy}, 32'd1);
      push(32'h00C2_00C1);
      wait_ready();
      check("abort_s0", {16'd0, data_out}, 32'h00C1);
      rd_step("abort_s1", 16'h00C2);
      rd_step("abort_end", 16'h00C2);
      check("abort_ready_end", {31'd0, ready}, 32'd0);

      // arm with trig and valid in the same cycle: only arm acts
      arm = 1'b1; trig_ext_en = 1'b1; capture_len = 4'd1; trig = 1'b1;
      valid = 1'b1; samp_in = 32'hBAD0_BAD0;
      tick();
      arm = 1'b0; trig_ext_en = 1'b0; trig = 1'b0;
      tick();
      valid = 1'b0;
      check("armtrig_count", {28'd0, samp_count}, 32'd0);
      check("armtrig_busy", {31'd0, busy}, 32'd1);
      trig = 1'b1;
      push(32'h00E2_00E1);
      trig = 1'b0;
      wait_ready();
      check("armtrig_s0", {16'd0, data_out}, 32'h00E1);
      rd_step("armtrig_s1", 16'h00E2);
      rd_step("armtrig_end", 16'h00E2);

      // Reset mid-capture, then a normal capture
      do_arm(1'b0, 4'd4);
      push(32'h0072_0071);
      push(32'h0074_0073);
      rst = 1'b1;
      tick();
      check("mrst_busy",  {31'd0, busy},  32'd0);
      check("mrst_ready", {31'd0, ready}, 32'd0);
      check("mrst_count", {28'd0, samp_count}, 32'd0);
      check("mrst_data",  {16'd0, data_out}, 32'd0);
      rst = 1'b0;
      tick();
      do_arm(1'b0, 4'd2);
      push(32'h0052_0051);
      push(32'h0054_0053);
      wait_ready();
      check("post_s0", {16'd0, data_out}, 32'h0051);
      rd_step("post_s1", 16'h0052);
      rd_step("post_s2", 16'h0053);
      rd_step("post_s3", 16'h0054);
      rd_step("post_end", 16'h0054);
      check("post_ready_end", {31'd0, ready}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
